booth_mul_seq: RTL and testbench

- Parametrised, iterative radix-2 Booth multiplier for the FP ALU mantissa datapath.
- Replaces the fixed single-step Booth pipeline stage.
- Takes operands of configurable width over a valid/ready handshake and runs one Booth step per clock under an FSM.
- Returns a full-width product with a signed/unsigned mode and a passthrough sideband tag (sign/exponent) plus zero flag.

---
 rtl/booth_mul_seq.sv | 160 ++++++++++++++++
 tb/tb_booth_mul_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - iterative radix-2 Booth multiplier with valid/ready handshake and tag passthrough
module booth_mul_seq #(
  parameter int WIDTH = 25,
  parameter int TAG_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [TAG_W-1:0]   tag_o,
  output logic               zero_o
);

  // One guard bit lets unsigned operands be treated as non-negative signed values,
  // so a single signed Booth recoding serves both modes.
  localparam int W     = WIDTH + 1;
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]       acc;
  logic [W-1:0]       mq;
  logic               q_m1;
  logic [W-1:0]       mcand;
  logic [CNT_W-1:0]   cnt;
  logic [TAG_W-1:0]   tag;

  logic [2*WIDTH-1:0] product_q;
  logic [TAG_W-1:0]   tag_q;
  logic               zero_q;

  logic               accept;
  logic               step;
  logic               last_step;
  logic [W-1:0]       ext_a;
  logic [W-1:0]       ext_b;
  logic [W-1:0]       booth_sum;
  logic [W-1:0]       acc_nxt;
  logic [W-1:0]       mq_nxt;
  logic [2*WIDTH-1:0] prod_nxt;

  // Flush outranks both the operand handshake and the iteration step.
  assign accept    = (state == IDLE) && in_valid && !flush;
  assign step      = (state == RUN) && !flush;
  assign last_step = step && (cnt == CNT_ONE);

  assign ext_a = {signed_mode & a[WIDTH-1], a};
  assign ext_b = {signed_mode & b[WIDTH-1], b};

  // Booth recoding of {mq[0], q_m1} followed by the arithmetic right shift of {acc, mq, q_m1}.
  always_comb begin
    booth_sum = acc;
    unique case ({mq[0], q_m1})
      2'b01:   booth_sum = acc + mcand;
      2'b10:   booth_sum = acc - mcand;
      default: booth_sum = acc;
    endcase
    acc_nxt  = {booth_sum[W-1], booth_sum[W-1:1]};
    mq_nxt   = {booth_sum[0], mq[W-1:1]};
    // The two guard bits at the top of {acc, mq} are pure sign copies and are dropped.
    prod_nxt = {acc_nxt[W-3:0], mq_nxt};
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_ONE) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
    end
  end

  // Operand capture and one Booth iteration per clock while running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      mq    <= '0;
      q_m1  <= 1'b0;
      mcand <= '0;
      cnt   <= '0;
      tag   <= '0;
    end else if (accept) begin
      acc   <= '0;
      mq    <= ext_b;
      q_m1  <= 1'b0;
      mcand <= ext_a;
      cnt   <= CNT_INIT;
      tag   <= tag_i;
    end else if (step) begin
      acc   <= acc_nxt;
      mq    <= mq_nxt;
      q_m1  <= mq[0];
      cnt   <= cnt - CNT_ONE;
    end
  end

  // Result registers load only on the final step so they hold across later operations.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      product_q <= '0;
      tag_q     <= '0;
      zero_q    <= 1'b0;
    end else if (last_step) begin
      product_q <= prod_nxt;
      tag_q     <= tag;
      zero_q    <= (prod_nxt == '0);
    end
  end

  assign product = product_q;
  assign tag_o   = tag_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - self-checking bench for booth_mul_seq against an arithmetic reference
module tb_booth_mul_seq;

  localparam int WIDTH = 8;
  localparam int TAG_W = 10;
  localparam int W     = WIDTH + 1;

  logic               clk;
  logic               reset;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [TAG_W-1:0]   tag_i;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic [TAG_W-1:0]   tag_o;
  logic               zero_o;

  int checks  = 0;
  int errors  = 0;
  int hs_seen = 0;
  int hs_exp  = 0;

  booth_mul_seq #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .signed_mode(signed_mode),
    .a(a),
    .b(b),
    .tag_i(tag_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product(product),
    .tag_o(tag_o),
    .zero_o(zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every result handshake so lost or duplicated results show up.
  always @(posedge clk) begin
    if (out_valid && out_ready) hs_seen <= hs_seen + 1;
  end

  function automatic logic [2*WIDTH-1:0] ref_mul(input logic sm, input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    longint p;
    if (sm) p = longint'($signed(x)) * longint'($signed(y));
    else    p = longint'(x) * longint'(y);
    return p[2*WIDTH-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic sm, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                          input logic [TAG_W-1:0] tg);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("ready_before_accept", in_ready, 1);
    signed_mode = sm;
    a           = aa;
    b           = bb;
    tag_i       = tg;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
    signed_mode = 1'($urandom);
    a           = WIDTH'($urandom);
    b           = WIDTH'($urandom);
    tag_i       = TAG_W'($urandom);
    chk("in_ready_in_run", in_ready, 0);
  endtask

  task automatic do_op(input logic sm, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                       input logic [TAG_W-1:0] tg, input int stall, input logic [2*WIDTH-1:0] exp_p);
    int n;
    start_op(sm, aa, bb, tg);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("latency", n, W);
    chk("product", product, exp_p);
    chk("tag_o", tag_o, tg);
    chk("zero_o", zero_o, (exp_p == '0));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_out_valid", out_valid, 1);
      chk("stall_product", product, exp_p);
      chk("stall_tag_o", tag_o, tg);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    hs_exp++;
    chk("out_valid_after_release", out_valid, 0);
    chk("in_ready_after_release", in_ready, 1);
  endtask

  initial begin
    int idle_at[$];
    int cyc;
    int ov_count;
    bit saw_valid;
    logic sm;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [TAG_W-1:0] rt;

    reset       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    tag_i       = '0;
    out_ready   = 1'b0;
    tick();
    tick();

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    chk("rst_tag_o", tag_o, 0);
    chk("rst_zero_o", zero_o, 0);
    reset = 1'b1;
    tick();

    do_op(1'b1, 8'hFD, 8'h05, 10'h155, 0, 16'hFFF1);
    do_op(1'b0, 8'hFF, 8'hFF, 10'h0AA, 0, 16'hFE01);
    do_op(1'b1, 8'h80, 8'h80, 10'h3C3, 0, 16'h4000);
    do_op(1'b1, 8'h00, 8'h7B, 10'h001, 0, 16'h0000);
    do_op(1'b0, 8'h01, 8'hFF, 10'h200, 0, 16'h00FF);
    do_op(1'b1, 8'h7B, 8'hC5, 10'h2F0, 20, 16'hE3A7);

    // Back-to-back with in_valid and out_ready held high.
    signed_mode = 1'b1;
    a           = 8'hFD;
    b           = 8'h05;
    tag_i       = 10'h2AA;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    cyc         = 0;
    ov_count    = 0;
    while (cyc < 100 && idle_at.size() < 4) begin
      if (out_valid) begin
        ov_count++;
        chk("b2b_product", product, 16'hFFF1);
      end
      if (in_ready) begin
        idle_at.push_back(cyc);
        if (idle_at.size() == 4) in_valid = 1'b0;
      end
      if (idle_at.size() < 4) begin
        tick();
        cyc++;
      end
    end
    out_ready = 1'b0;
    hs_exp += 3;
    chk("b2b_accept_count", idle_at.size(), 4);
    chk("b2b_result_count", ov_count, 3);
    if (idle_at.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("b2b_period", idle_at[i] - idle_at[i-1], W + 2);
    end

    // Asynchronous reset in the middle of a run.
    start_op(1'b1, 8'h55, 8'h66, 10'h111);
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_product", product, 0);
    chk("midrst_tag_o", tag_o, 0);
    tick();
    reset = 1'b1;
    tick();
    do_op(1'b0, 8'h01, 8'hFF, 10'h0F0, 1, 16'h00FF);

    // Flush in the middle of a run, with a competing in_valid.
    start_op(1'b1, 8'h12, 8'h34, 10'h321);
    tick();
    tick();
    tick();
    flush       = 1'b1;
    in_valid    = 1'b1;
    signed_mode = 1'b0;
    a           = 8'hAA;
    b           = 8'hBB;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_out_valid", out_valid, 0);
    tick();
    chk("flush_in_valid_ignored", in_ready, 1);
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) saw_valid = 1'b1;
      tick();
    end
    chk("flush_no_result", saw_valid, 0);
    do_op(1'b1, 8'h7F, 8'h81, 10'h3FF, 2, 16'hC0FF);

    // Randomized operations with random result stalls.
    for (int i = 0; i < 2000; i++) begin
      sm = 1'($urandom);
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rt = TAG_W'($urandom);
      if (i % 16 == 0) begin
        ra = sm ? 8'h80 : 8'hFF;
        rb = sm ? 8'h80 : 8'hFF;
      end
      do_op(sm, ra, rb, rt, int'($urandom_range(0, 3)), ref_mul(sm, ra, rb));
    end

    tick();
    chk("handshake_count", hs_seen, hs_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
